// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the async FIFO pointer handlers.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   PTR_WIDTH_DEF : default address width (FIFO depth 2**PTR_WIDTH_DEF)
//   ptr_t         : pointer type at the default width (address bits + wrap bit)
package async_fifo_pkg;

  localparam int PTR_WIDTH_DEF = 3;

  typedef logic [PTR_WIDTH_DEF:0] ptr_t;

endpackage

// File: rtl/gray2bin.sv
// Gray-code to binary converter, parameterized by width.
// Latency: purely combinational.
// Backpressure: not applicable.
//
// Ports:
//   gray : Gray-coded input
//   bin  : binary equivalent; each bit is the XOR of all Gray bits at or above it
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/wptr_handler.sv
// Write-side pointer and flag logic for an asynchronous FIFO.
// Latency: pointers and flags register on the w_clk edge that accepts a write; w_mem_en is combinational.
// Backpressure: writes are refused (w_mem_en low, pointers held) while full is set.
//
// Build option: define WPTR_OVERFLOW_EN to add the sticky overflow output.
//
// Ports:
//   w_clk, w_rst_n : write clock, asynchronous active-low reset
//   w_en           : write request
//   g_rptr_sync    : Gray read pointer, already synchronized into w_clk
//   b_wptr         : binary write pointer (low PTR_WIDTH bits address memory)
//   g_wptr         : Gray write pointer for the read-side synchronizer
//   w_mem_en       : memory write strobe
//   full           : FIFO full
//   almost_full    : fill level >= AFULL_THRESH
//   w_level        : fill level, 0..2**PTR_WIDTH
//   overflow       : sticky write-while-full flag (WPTR_OVERFLOW_EN only)
module wptr_handler
  import async_fifo_pkg::*;
#(
  parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
  parameter int AFULL_THRESH = 6
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  input  logic               w_en,
  input  logic [PTR_WIDTH:0] g_rptr_sync,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               w_mem_en,
  output logic               full,
  output logic               almost_full,
  output logic [PTR_WIDTH:0] w_level
`ifdef WPTR_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam logic [PTR_WIDTH:0] AFULL_LVL = (PTR_WIDTH + 1)'(AFULL_THRESH);

  logic [PTR_WIDTH:0] b_wptr_next;
  logic [PTR_WIDTH:0] g_wptr_next;
  logic [PTR_WIDTH:0] rbin;
  logic [PTR_WIDTH:0] level_next;
  logic [PTR_WIDTH:0] g_rptr_full;

  // Gating with w_rst_n keeps the memory from being written while reset is held.
  assign w_mem_en    = w_en && !full && w_rst_n;

  assign b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, w_mem_en};
  assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

  // Full when the write pointer is one lap ahead of the read pointer: in Gray
  // code that is the top two bits inverted and the rest equal.
  assign g_rptr_full = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};

  gray2bin #(
    .WIDTH(PTR_WIDTH + 1)
  ) u_rptr_g2b (
    .gray(g_rptr_sync),
    .bin (rbin)
  );

  // Modulo subtraction gives the true fill level since the two pointers never
  // differ by more than one lap.
  assign level_next = b_wptr_next - rbin;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      w_level     <= '0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      full        <= (g_wptr_next == g_rptr_full);
      almost_full <= (level_next >= AFULL_LVL);
      w_level     <= level_next;
    end
  end

`ifdef WPTR_OVERFLOW_EN
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      overflow <= 1'b0;
    end else if (w_en && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_handler.sv
// Directed self-checking bench for wptr_handler (PTR_WIDTH=3, AFULL_THRESH=6).
// Expected pointer/flag values come from a write/read count model and are
// queued when stimulus is applied, then popped and compared after the edge.
module tb_wptr_handler;

  logic       w_clk;
  logic       w_rst_n;
  logic       w_en;
  logic [3:0] g_rptr_sync;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       w_mem_en;
  logic       full;
  logic       almost_full;
  logic [3:0] w_level;
`ifdef WPTR_OVERFLOW_EN
  logic       overflow;
`endif

  wptr_handler #(
    .PTR_WIDTH   (3),
    .AFULL_THRESH(6)
  ) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_en       (w_en),
    .g_rptr_sync(g_rptr_sync),
    .b_wptr     (b_wptr),
    .g_wptr     (g_wptr),
    .w_mem_en   (w_mem_en),
    .full       (full),
    .almost_full(almost_full),
    .w_level    (w_level)
`ifdef WPTR_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] lvl;
    logic       full;
    logic       af;
    logic       acc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   wcnt     = 0;   // accepted writes since reset
  int   rcnt     = 0;   // reads seen through g_rptr_sync since reset
  logic mfull    = 1'b0;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, predict, wait for the edge, compare.
  task automatic drive(input logic we, input int rnew);
    exp_t       e;
    int         lvl;
    logic [3:0] wb;
    logic [3:0] rb;
    logic [3:0] prev_g;
    rb          = rnew[3:0];
    w_en        = we;
    rcnt        = rnew;
    g_rptr_sync = gray4(rb);
    #1;
    e.acc = we && !mfull;
    chk("w_mem_en", 32'(w_mem_en), 32'(e.acc));
    if (e.acc) wcnt++;
    lvl    = wcnt - rcnt;
    wb     = wcnt[3:0];
    e.b    = wb;
    e.g    = gray4(wb);
    e.lvl  = lvl[3:0];
    e.full = (lvl == 8);
    e.af   = (lvl >= 6);
    q.push_back(e);
    prev_g = g_wptr;
    @(posedge w_clk);
    #1;
    e = q.pop_front();
    chk("b_wptr", 32'(b_wptr), 32'(e.b));
    chk("g_wptr", 32'(g_wptr), 32'(e.g));
    chk("w_level", 32'(w_level), 32'(e.lvl));
    chk("full", 32'(full), 32'(e.full));
    chk("almost_full", 32'(almost_full), 32'(e.af));
    chk("gray_step", 32'($countones(g_wptr ^ prev_g)), 32'(e.acc));
    mfull = e.full;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_b_wptr"}, 32'(b_wptr), 32'd0);
    chk({tag, "_g_wptr"}, 32'(g_wptr), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_level"}, 32'(w_level), 32'd0);
    chk({tag, "_mem_en"}, 32'(w_mem_en), 32'd0);
`ifdef WPTR_OVERFLOW_EN
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
`endif
  endtask

  initial begin
    w_rst_n     = 1'b0;
    w_en        = 1'b1;
    g_rptr_sync = 4'd0;
    #12;
    check_all_zero("por");
    w_en = 1'b0;
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // Fill: eight writes, almost_full from the 6th, full at the 8th.
    for (int i = 0; i < 8; i++) drive(1'b1, 0);
    chk("g_wptr_at_8", 32'(g_wptr), 32'(4'b1100));
    chk("level_at_8", 32'(w_level), 32'd8);

    // Blocked write while full.
    drive(1'b1, 0);
    chk("blocked_b_wptr", 32'(b_wptr), 32'd8);
`ifdef WPTR_OVERFLOW_EN
    chk("overflow_set", 32'(overflow), 32'd1);
`endif

    // Drain one entry, then refill it.
    drive(1'b0, 1);
    chk("drain_level", 32'(w_level), 32'd7);
    drive(1'b1, 1);
    chk("refull", 32'(full), 32'd1);

    // Asynchronous reset in the middle of a clock phase with a write pending.
    @(posedge w_clk);
    #3;
    w_en    = 1'b1;
    w_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    wcnt        = 0;
    rcnt        = 0;
    mfull       = 1'b0;
    w_en        = 1'b0;
    g_rptr_sync = 4'd0;
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // Wrap: 16 writes each followed by a matching read.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, rcnt);
      drive(1'b0, rcnt + 1);
    end
    chk("wrap_b_wptr", 32'(b_wptr), 32'd0);

    // Simultaneous write and read at level 5.
    for (int i = 0; i < 5; i++) drive(1'b1, rcnt);
    chk("pre_sim_level", 32'(w_level), 32'd5);
    drive(1'b1, rcnt + 1);
    chk("sim_level", 32'(w_level), 32'd5);
    chk("sim_afull", 32'(almost_full), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wptr_handler.md
WPTR_HANDLER -- requirements
Module: wptr_handler

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 3; address width, FIFO depth 2**PTR_WIDTH, pointers PTR_WIDTH+1 bits.
REQ-002 SHALL have parameter AFULL_THRESH, default 6; fill level at or above which almost_full asserts; legal range 1..2**PTR_WIDTH.
REQ-003 SHALL have port w_clk  input  1  write-domain clock; the block has one clock.
REQ-004 SHALL have port w_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port w_en  input  1  write request.
REQ-006 SHALL have port g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronized into w_clk.
REQ-007 SHALL have port b_wptr  output  PTR_WIDTH+1  registered binary write pointer; low PTR_WIDTH bits address memory.
REQ-008 SHALL have port g_wptr  output  PTR_WIDTH+1  registered Gray write pointer, for the read-side synchronizer.
REQ-009 SHALL have port w_mem_en  output  1  combinational memory write strobe.
REQ-010 SHALL have port full  output  1  registered full flag.
REQ-011 SHALL have port almost_full  output  1  registered almost-full flag.
REQ-012 SHALL have port w_level  output  PTR_WIDTH+1  registered fill level, 0..2**PTR_WIDTH.
REQ-013 SHALL have port overflow  output  1  sticky overflow flag; exists only when WPTR_OVERFLOW_EN is defined.

Function
REQ-014 SHALL drive w_mem_en = w_en && !full; a write is accepted only in cycles where w_mem_en is 1.
REQ-015 SHALL compute b_wptr_next = b_wptr + w_mem_en, modulo 2**(PTR_WIDTH+1); the MSB is the wrap bit.
REQ-016 SHALL compute g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next, then register both pointers every w_clk edge; zero added latency.
REQ-017 SHALL register full <= (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}).
REQ-018 SHALL convert g_rptr_sync to binary rbin (XOR prefix from MSB) and register w_level <= b_wptr_next - rbin, PTR_WIDTH+1 bits, unsigned modulo.
REQ-019 SHALL register almost_full <= (b_wptr_next - rbin) >= AFULL_THRESH; full implies almost_full.
REQ-020 SHALL, for w_en while full, leave pointers unchanged and keep full asserted.
REQ-021 SHALL, for a read-pointer advance in the same cycle as an accepted write, use the new g_rptr_sync in flags; level unchanged, full deasserts if it was set.
REQ-022 SHALL treat flags as pessimistic: the synchronizer lag may report full/level high, never low.
REQ-023 SHALL wrap pointers from all-ones to zero with the Gray code changing exactly one bit per increment.

Reset
REQ-024 SHALL, on w_rst_n low, asynchronously set b_wptr=0, g_wptr=0, full=0, almost_full=0, w_level=0, overflow=0.
REQ-025 SHALL abort an in-progress write on mid-operation reset; w_mem_en is 0 while w_rst_n is low.
REQ-026 SHALL resume normal updates on the first w_clk rising edge after w_rst_n deasserts.

Configuration
REQ-027 SHALL, with WPTR_OVERFLOW_EN defined, set overflow on any edge where w_en && full, and hold it until reset.
REQ-028 SHALL, without WPTR_OVERFLOW_EN, omit the overflow port and logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL place the default PTR_WIDTH constant and a pointer-width typedef in shared package async_fifo_pkg, used by both pointer handlers.
REQ-030 SHALL implement Gray-to-binary conversion in sub-module gray2bin, parameterized by width, combinational.

Verification (PTR_WIDTH=3, AFULL_THRESH=6, g_rptr_sync held 0 unless stated)
REQ-031 SHALL check reset: w_rst_n=0 asynchronously mid-clock -> all outputs 0 immediately.
REQ-032 SHALL check fill: 8 consecutive w_en -> b_wptr 1..8, g_wptr=4'b1100 at 8, almost_full after 6th write, full after 8th, w_level=8.
REQ-033 SHALL check blocked write: w_en while full -> b_wptr stays 8, w_mem_en=0, overflow=1 only with WPTR_OVERFLOW_EN.
REQ-034 SHALL check drain: full with g_rptr_sync stepped to Gray(1) -> full=0 next edge, w_level=7; one more write -> full=1.
REQ-035 SHALL check wrap: 16 writes interleaved with matching reads -> b_wptr returns 0, one Gray bit changes per step, full never asserts.
REQ-036 SHALL check simultaneous events: write and read advance in the same cycle at level 5 -> level stays 5, almost_full stays 0.
